// File: rtl/clk_monitor.sv
// clk_monitor: measures the high/low phases of an asynchronous clock in clk
// cycles, declares lock after a run of in-tolerance phases, and reports
// short, long and stuck phases once locked.
module clk_monitor #(
    parameter int unsigned EXP_HALF = 8,
    parameter int unsigned TOL      = 1,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mon_clk,
    input  logic          enable,
    input  logic          clear,
    output logic          locked,
    output logic          err_pulse,
    output logic [1:0]    err_code,
    output logic          err_sticky,
    output logic [CW-1:0] high_cnt,
    output logic [CW-1:0] low_cnt,
    output logic [15:0]   edge_cnt
);

    localparam int unsigned MW = CW + 1;
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);

    localparam logic [MW-1:0] M_LO      = MW'(EXP_HALF - TOL);
    localparam logic [MW-1:0] M_HI      = MW'(EXP_HALF + TOL);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_SHORT = 2'b01;
    localparam logic [1:0] CODE_LONG  = 2'b10;
    localparam logic [1:0] CODE_STUCK = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            s1;
    logic            s2;
    logic            s3;
    logic            mon_edge;
    logic            timeout;
    logic [CW-1:0]   run_cnt;
    logic [CW-1:0]   run_cnt_d;
    logic [GW-1:0]   good_cnt;
    logic [GW-1:0]   good_cnt_d;
    logic [MW-1:0]   m;
    logic            m_good;
    logic            m_short;
    logic            err_pulse_d;
    logic [1:0]      err_code_d;
    logic            err_sticky_d;
    logic [CW-1:0]   high_cnt_d;
    logic [CW-1:0]   low_cnt_d;
    logic [15:0]     edge_cnt_d;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Edge, measurement and timeout decode
    always_comb begin
        mon_edge = s2 ^ s3;
        m        = MW'(run_cnt) + MW'(1);
        m_good   = (m >= M_LO) && (m <= M_HI);
        m_short  = (m < M_LO);
        timeout  = !mon_edge && (run_cnt == TO_LAST);
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt;
        good_cnt_d   = good_cnt;
        err_pulse_d  = 1'b0;
        err_code_d   = err_code;
        high_cnt_d   = high_cnt;
        low_cnt_d    = low_cnt;
        edge_cnt_d   = edge_cnt;
        err_sticky_d = err_sticky;

        if (state_q != IDLE) begin
            if (mon_edge || timeout) begin
                run_cnt_d = '0;
            end else if (run_cnt != '1) begin
                run_cnt_d = run_cnt + CW'(1);
            end
            if (mon_edge && s2) begin
                edge_cnt_d = edge_cnt + 16'd1;
            end
            if (mon_edge && (state_q == TRACK || state_q == LOCKED)) begin
                if (s2) begin
                    low_cnt_d = m[CW-1:0];
                end else begin
                    high_cnt_d = m[CW-1:0];
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE: begin
                // First interval is partial: only start tracking on it
                if (mon_edge) begin
                    state_d    = TRACK;
                    good_cnt_d = '0;
                end else if (timeout) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = CODE_STUCK;
                end
            end
            TRACK: begin
                if (mon_edge) begin
                    if (m_good) begin
                        good_cnt_d = good_cnt + GW'(1);
                        if (good_cnt + GW'(1) == LOCK_LAST) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end else if (timeout) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = CODE_STUCK;
                    state_d     = ACQUIRE;
                end
            end
            LOCKED: begin
                if (mon_edge) begin
                    if (!m_good) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = m_short ? CODE_SHORT : CODE_LONG;
                        good_cnt_d  = '0;
                        state_d     = TRACK;
                    end
                end else if (timeout) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = CODE_STUCK;
                    state_d     = ACQUIRE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable overrides everything; measurement history is kept
        if (!enable) begin
            state_d     = IDLE;
            run_cnt_d   = '0;
            good_cnt_d  = '0;
            err_pulse_d = 1'b0;
            err_code_d  = CODE_NONE;
        end

        // A pending or current error pulse wins over clear
        if (err_pulse_d || err_pulse) begin
            err_sticky_d = 1'b1;
        end else if (clear) begin
            err_sticky_d = 1'b0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            run_cnt    <= '0;
            good_cnt   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= CODE_NONE;
            err_sticky <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            edge_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            run_cnt    <= run_cnt_d;
            good_cnt   <= good_cnt_d;
            locked     <= (state_d == LOCKED);
            err_pulse  <= err_pulse_d;
            err_code   <= err_code_d;
            err_sticky <= err_sticky_d;
            high_cnt   <= high_cnt_d;
            low_cnt    <= low_cnt_d;
            edge_cnt   <= edge_cnt_d;
        end
    end

endmodule

// File: tb/tb_clk_monitor.sv
// Testbench for clk_monitor: phase-level reference model feeding an event
// scoreboard (lock rises and error pulses with their exact output cycle).
`timescale 1ns/1ps
module tb_clk_monitor;

    localparam int H  = 8;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mon_clk;
    logic        enable;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic        err_sticky;
    logic [15:0] high_cnt;
    logic [15:0] low_cnt;
    logic [15:0] edge_cnt;

    clk_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mon_clk    (mon_clk),
        .enable     (enable),
        .clear      (clear),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .edge_cnt   (edge_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_lock;
        logic [1:0] code;
        int         at;
    } evt_t;

    evt_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Phase-level reference model: 0 idle, 1 acquire, 2 track, 3 locked
    int          mst      = 0;
    int          good     = 0;
    int          last_t   = 0;
    int          exp_high = 0;
    int          exp_low  = 0;
    int          exp_code = 0;
    bit          exp_sticky = 1'b0;
    logic [15:0] exp_edge = 16'd0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_tol(input int m);
        return (m >= H - 1) && (m <= H + 1);
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_locked"}, locked, (mst == 3) ? 1 : 0);
        check({tag, "_err_pulse"}, err_pulse, 0);
        check({tag, "_err_code"}, err_code, exp_code);
        check({tag, "_sticky"}, err_sticky, exp_sticky);
        check({tag, "_high"}, high_cnt, exp_high);
        check({tag, "_low"}, low_cnt, exp_low);
        check({tag, "_edges"}, edge_cnt, exp_edge);
    endtask

    // Flip mon_clk on a negedge; predict measurement, events and timeouts
    // expected before the next toggle, which comes len cycles later.
    task automatic toggle_now(input int len);
        int t;
        int m;
        @(negedge clk);
        mon_clk = ~mon_clk;
        t = cyc;
        if (mst != 0) begin
            m = t - last_t;
            if (mon_clk) exp_edge = exp_edge + 16'd1;
            if (mst == 2 || mst == 3) begin
                if (mon_clk) exp_low = m;
                else exp_high = m;
            end
            case (mst)
                1: begin
                    mst  = 2;
                    good = 0;
                end
                2: begin
                    if (in_tol(m)) begin
                        good++;
                        if (good == 4) begin
                            mst = 3;
                            sb.push_back('{is_lock: 1'b1, code: 2'd0, at: t + 3});
                        end
                    end else begin
                        good = 0;
                    end
                end
                3: begin
                    if (!in_tol(m)) begin
                        exp_code   = (m < H - 1) ? 1 : 2;
                        exp_sticky = 1'b1;
                        sb.push_back('{is_lock: 1'b0, code: 2'(exp_code), at: t + 3});
                        mst  = 2;
                        good = 0;
                    end
                end
                default: ;
            endcase
            for (int k = 1; TO * k < len; k++) begin
                sb.push_back('{is_lock: 1'b0, code: 2'd3, at: t + 3 + TO * k});
                exp_code   = 3;
                exp_sticky = 1'b1;
                mst        = 1;
                good       = 0;
            end
        end
        last_t = t;
    endtask

    task automatic phase(input int len);
        toggle_now(len);
        repeat (len - 1) @(negedge clk);
    endtask

    task automatic do_enable();
        @(negedge clk);
        enable = 1'b1;
        mst    = 1;
        good   = 0;
        last_t = cyc - 2;
    endtask

    task automatic do_disable(input string tag);
        @(negedge clk);
        enable   = 1'b0;
        mst      = 0;
        good     = 0;
        exp_code = 0;
        repeat (2) @(negedge clk);
        check_regs(tag);
        check({tag, "_sb_drain"}, sb.size(), 0);
    endtask

    // Scoreboard consumer: every lock rise or error pulse pops one event
    bit   locked_q = 1'b0;
    evt_t mon_e;
    always @(negedge clk) begin
        if (rst_n && (err_pulse || (locked && !locked_q))) begin
            check("sb_pending", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("evt_kind", err_pulse ? 0 : 1, mon_e.is_lock);
                check("evt_cycle", cyc, mon_e.at);
                if (err_pulse) begin
                    check("evt_err_code", err_code, mon_e.code);
                    check("evt_unlocked", locked, 0);
                end
            end
        end
        locked_q = locked;
    end

    int ts;

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        mon_clk = 1'b0;
        repeat (3) @(negedge clk);
        check_regs("por");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Ideal clock: lock on the 5th edge
        do_enable();
        repeat (6) phase(H);
        check_regs("ideal");

        // Boundary phases 7/9 keep lock, 6 is short, then relock
        phase(7); phase(9); phase(7); phase(9); phase(6);
        check_regs("bound");
        phase(H);
        check_regs("short");
        repeat (5) phase(H);
        check_regs("relock_short");

        // Long phase of 10
        phase(10);
        phase(H);
        check_regs("long");
        repeat (5) phase(H);
        check_regs("relock_long");

        // Stuck clock with clear interplay
        toggle_now(200);
        ts = cyc;
        repeat (10) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check("clr_alone_a", err_sticky, 0);
        repeat (TO + 3 - 12) @(negedge clk);
        check("stuck_at", cyc - ts, TO + 3);
        check("stuck_pulse", err_pulse, 1);
        clear = 1'b1;
        @(negedge clk);
        check("clr_same_cycle", err_sticky, 1);
        @(negedge clk);
        check("clr_alone_b", err_sticky, 0);
        clear = 1'b0;
        repeat (199 - (TO + 5)) @(negedge clk);
        check_regs("stuck");
        repeat (6) phase(H);
        check_regs("relock_stuck");

        // Enable dropped mid-lock, then relock
        do_disable("disable");
        do_enable();
        repeat (4) phase(H);
        check("no_lock_4_edges", locked, 0);
        repeat (2) phase(H);
        check_regs("reenable");

        // Asynchronous reset mid-lock, then relock
        @(negedge clk);
        check("sb_drain_rst", sb.size(), 0);
        #1;
        rst_n    = 1'b0;
        enable   = 1'b0;
        mst      = 0;
        good     = 0;
        exp_code = 0;
        exp_sticky = 1'b0;
        exp_high = 0;
        exp_low  = 0;
        exp_edge = 16'd0;
        #1;
        check_regs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_enable();
        repeat (6) phase(H);
        check_regs("post_rst");

        do_disable("final");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_monitor.md
# clk_monitor

Synthesizable checker for an externally supplied clock (`mon_clk`), sampled in the `clk` domain. It is the measuring end of the clock-generation path: the generator produces a clock with a fixed period, and this block verifies that period. It synchronizes `mon_clk`, measures every high and low phase in `clk` cycles, and declares lock after a run of in-tolerance phases. Once locked, it reports short, long and stuck phases as error pulses and as a sticky flag.

## Interface
- `EXP_HALF`, 8: expected half-period of `mon_clk`, in `clk` cycles.
- `TOL`, 1: allowed deviation (inclusive) from `EXP_HALF`.
- `LOCK_CNT`, 4: consecutive good measurements required to lock.
- `TIMEOUT`, 64: `clk` cycles without a `mon_clk` edge that count as stuck. Must be greater than `EXP_HALF+TOL`.
- `CW`, 16: width of the measurement counters. Must hold `TIMEOUT`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mon_clk`  in  1  monitored clock, asynchronous to `clk`.
- `enable`  in  1  1 = monitor active; 0 = return to IDLE.
- `clear`  in  1  clears `err_sticky`.
- `locked`  out  1  1 while in LOCKED.
- `err_pulse`  out  1  one-cycle strobe on each error.
- `err_code`  out  2  code of the last error: 00 none, 01 short, 10 long, 11 stuck. Held until the next error or until IDLE.
- `err_sticky`  out  1  set by `err_pulse`, cleared by `clear`.
- `high_cnt`  out  CW  last measured high phase.
- `low_cnt`  out  CW  last measured low phase.
- `edge_cnt`  out  16  rising edges seen while not IDLE; wraps modulo 2^16.

## Operation
- Input path: 2-flop synchronizer `s1`→`s2`, plus `s3` (`s2` delayed one cycle).
- Edge detection: `edge = s2^s3`. Rising when `s2=1`, falling when `s2=0`.
- `run_cnt` (CW bits, saturating):
  - cleared to 0 on an edge cycle, otherwise incremented;
  - in IDLE, held at 0 (as are `s1..s3`-derived counters).
- Measurement on an edge cycle: `m = run_cnt+1`, computed at CW+1 bits.
  - An ideal clock with half-period H gives `m = H`.
- Classification of `m`:
  - good: `EXP_HALF-TOL ≤ m ≤ EXP_HALF+TOL`;
  - short: below that range;
  - long: above that range.
- Timeout: not an edge cycle and `run_cnt == TIMEOUT-1`. `run_cnt` is then cleared.
- States:
  - **IDLE**: `enable=1` → ACQUIRE.
  - **ACQUIRE**: the first interval is partial and is not measured.
    - edge → TRACK, with `good_cnt=0`;
    - timeout → stuck error, stay in ACQUIRE.
  - **TRACK**, on an edge:
    - good: `good_cnt++`; if `good_cnt+1 == LOCK_CNT` → LOCKED;
    - bad: `good_cnt=0` and no error is reported;
    - timeout → stuck error, go to ACQUIRE.
  - **LOCKED**:
    - bad edge → short or long error, `good_cnt=0`, go to TRACK;
    - timeout → stuck error, go to ACQUIRE.
- `enable=0` in any state → IDLE on the next edge of `clk`. This clears `locked`, `err_code`, `good_cnt` and `run_cnt`. `err_sticky`, `edge_cnt`, `high_cnt` and `low_cnt` are held.
- In TRACK and LOCKED, a falling-edge measurement loads `high_cnt=m[CW-1:0]` and a rising-edge measurement loads `low_cnt`.
- `edge_cnt` increments on every rising edge in ACQUIRE, TRACK and LOCKED.
- `err_sticky`:
  - set on `err_pulse`; `clear` deasserts it;
  - if `clear` and `err_pulse` occur in the same cycle, `err_sticky` stays 1.

## Timing
- Reset: state IDLE; all outputs, counters and sync flops are 0.
- Input latency: a `mon_clk` transition sampled at `clk` edge k is in `s2` after k+1, is the edge cycle between k+1 and k+2, and updates registered outputs at k+2.
- All outputs are registered. `err_pulse` is high for exactly one cycle.
- `locked` rises on the same `clk` edge that commits the LOCK_CNT-th good measurement. It falls on the same edge as an error `err_pulse`.
- Asynchronous reset mid-operation: immediate return to reset values, then IDLE. The first measurement after reset is again discarded in ACQUIRE.
- `clear` acts in one cycle.

## Test plan
- Ideal clock (H=8), `enable=1`: `locked=1` after the 5th detected edge (1 acquire + 4 good); `high_cnt=low_cnt=8`; no `err_pulse`.
- Boundary phases of 7 and 9 while locked: stay locked. A phase of 6 → `err_pulse`, `err_code=01`, `locked=0`, and relock after 4 good phases.
- Phase of 10 while locked: `err_code=10`, `err_sticky=1`, and `high_cnt` or `low_cnt` = 10.
- `mon_clk` held constant after lock: `err_code=11` exactly 64 cycles after the last edge cycle, state ACQUIRE, then a repeat pulse every 64 cycles.
- `clear` in the same cycle as an `err_pulse`: `err_sticky` stays 1. `clear` alone on the following cycle: `err_sticky=0`.
- `rst_n` low mid-lock and `enable` dropped mid-lock: all outputs as specified (reset → all 0; `enable=0` → IDLE with held counters), and relock takes 5 edges again.
